// File: rtl/snake_motion_ctrl.sv
// Snake game-logic stage: head/fruit/score state, tick timing and painter handshake.
// Optional build macro SNAKE_WRAP_EN: wrap at the playable border instead of ending the game.
module snake_motion_ctrl #(
  parameter int CELL_PX     = 16,
  parameter int GRID_W      = 40,
  parameter int GRID_H      = 30,
  parameter int TICK_CYCLES = 5_000_000,
  parameter int START_X     = 20,
  parameter int START_Y     = 15,
  parameter int SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               start,
  input  logic               painter_busy,
  output logic [9:0]         x_min_px,
  output logic [9:0]         x_max_px,
  output logic [9:0]         y_min_px,
  output logic [9:0]         y_max_px,
  output logic [9:0]         fruit_cx,
  output logic [9:0]         fruit_cy,
  output logic               redraw,
  output logic               game_over,
  output logic [SCORE_W-1:0] score
);

  localparam int SHIFT  = $clog2(CELL_PX);
  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  localparam logic [5:0] COL_MAX = 6'(GRID_W - 2);
  localparam logic [5:0] ROW_MAX = 6'(GRID_H - 2);
  localparam logic [5:0] HX_INIT = 6'(START_X);
  localparam logic [5:0] HY_INIT = 6'(START_Y);
  localparam logic [5:0] FRUIT_INIT = 6'd10;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [2:0] S_WAIT  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_FRUIT = 3'd3;
  localparam logic [2:0] S_DRAW  = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  logic [4:0]         btn_raw;
  logic [4:0]         sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [4:0]         btn_edge;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [2:0]         state_q, state_d;
  logic [5:0]         hx_q, hx_d, hy_q, hy_d, fx_q, fx_d, fy_q, fy_d;
  logic [1:0]         dir_q, dir_d, pend_q, pend_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               over_q, over_d;

  logic [1:0] req_dir, pend_eff;
  logic       key_any, off_grid, cand_ok;
  logic [5:0] nx, ny, cand_x, cand_y;

  // Bit order: up, down, left, right, start.
  assign btn_raw  = {start, key_right, key_left, key_down, key_up};
  assign btn_edge = sync2_q & ~prev_q;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Direction encoding makes the opposite direction dir ^ 1.
  always_comb begin
    key_any = |btn_edge[3:0];
    if (btn_edge[0])      req_dir = DIR_UP;
    else if (btn_edge[1]) req_dir = DIR_DOWN;
    else if (btn_edge[2]) req_dir = DIR_LEFT;
    else                  req_dir = DIR_RIGHT;
    pend_eff = pend_q;
    if (key_any && (req_dir != (dir_q ^ 2'b01))) pend_eff = req_dir;

    nx = hx_q;
    ny = hy_q;
    case (pend_eff)
      DIR_UP:   ny = hy_q - 6'd1;
      DIR_DOWN: ny = hy_q + 6'd1;
      DIR_LEFT: nx = hx_q - 6'd1;
      default:  nx = hx_q + 6'd1;
    endcase
`ifdef SNAKE_WRAP_EN
    if (nx == 6'd0)               nx = COL_MAX;
    else if (nx == COL_MAX + 6'd1) nx = 6'd1;
    if (ny == 6'd0)               ny = ROW_MAX;
    else if (ny == ROW_MAX + 6'd1) ny = 6'd1;
    off_grid = 1'b0;
`else
    off_grid = (nx == 6'd0) || (nx == COL_MAX + 6'd1) ||
               (ny == 6'd0) || (ny == ROW_MAX + 6'd1);
`endif

    cand_x  = lfsr_q[5:0];
    cand_y  = lfsr_q[13:8];
    cand_ok = (cand_x != 6'd0) && (cand_x <= COL_MAX) &&
              (cand_y != 6'd0) && (cand_y <= ROW_MAX) &&
              !((cand_x == hx_q) && (cand_y == hy_q));
  end

  always_comb begin
    state_d = state_q;
    hx_d    = hx_q;
    hy_d    = hy_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    tick_d  = tick_q;
    score_d = score_q;
    over_d  = over_q;
    case (state_q)
      S_WAIT: if (!painter_busy) state_d = S_READY;
      S_READY: begin
        if (btn_edge[4]) begin
          state_d = S_RUN;
          tick_d  = '0;
        end
      end
      S_RUN: begin
        pend_d = pend_eff;
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          dir_d  = pend_eff;
          if (off_grid) begin
            over_d  = 1'b1;
            state_d = S_OVER;
          end else begin
            hx_d = nx;
            hy_d = ny;
            if ((nx == fx_q) && (ny == fy_q)) begin
              if (score_q != {SCORE_W{1'b1}}) score_d = score_q + 1'b1;
              state_d = S_FRUIT;
            end else begin
              state_d = S_DRAW;
            end
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_FRUIT: begin
        if (cand_ok) begin
          fx_d    = cand_x;
          fy_d    = cand_y;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        if (!painter_busy) begin
          tick_d  = '0;
          state_d = S_RUN;
        end
      end
      S_OVER: begin
        if (btn_edge[4]) begin
          hx_d    = HX_INIT;
          hy_d    = HY_INIT;
          fx_d    = FRUIT_INIT;
          fy_d    = FRUIT_INIT;
          dir_d   = DIR_RIGHT;
          pend_d  = DIR_RIGHT;
          tick_d  = '0;
          score_d = '0;
          over_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      lfsr_q  <= 16'hACE1;
      state_q <= S_WAIT;
      hx_q    <= HX_INIT;
      hy_q    <= HY_INIT;
      fx_q    <= FRUIT_INIT;
      fy_q    <= FRUIT_INIT;
      dir_q   <= DIR_RIGHT;
      pend_q  <= DIR_RIGHT;
      tick_q  <= '0;
      score_q <= '0;
      over_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      lfsr_q  <= lfsr_d;
      state_q <= state_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      score_q <= score_d;
      over_q  <= over_d;
    end
  end

  // Redraw is combinational so it can never coincide with a busy painter.
  assign redraw    = (state_q == S_DRAW) && !painter_busy;
  assign game_over = over_q;
  assign score     = score_q;

  assign x_min_px = {4'b0, hx_q} << SHIFT;
  assign y_min_px = {4'b0, hy_q} << SHIFT;
  assign x_max_px = x_min_px + 10'(CELL_PX - 1);
  assign y_max_px = y_min_px + 10'(CELL_PX - 1);
  assign fruit_cx = ({4'b0, fx_q} << SHIFT) + 10'(CELL_PX / 2);
  assign fruit_cy = ({4'b0, fy_q} << SHIFT) + 10'(CELL_PX / 2);

endmodule

// File: tb/tb_snake_motion_ctrl.sv
// Directed bench for snake_motion_ctrl: four instances with different start cells / tick lengths
// share stimulus; each phase resets all of them and checks one.
module tb_snake_motion_ctrl;

  logic       clk;
  logic       resetn;
  logic [4:0] btn;   // up, down, left, right, start
  logic       busy;

  logic [9:0] xmin [4];
  logic [9:0] xmax [4];
  logic [9:0] ymin [4];
  logic [9:0] ymax [4];
  logic [9:0] fcx  [4];
  logic [9:0] fcy  [4];
  logic       rd   [4];
  logic       go   [4];
  logic [7:0] sc   [4];

  int checks = 0;
  int errors = 0;
  int rd_cnt [4] = '{0, 0, 0, 0};

  localparam logic [4:0] K_U = 5'b00001;
  localparam logic [4:0] K_D = 5'b00010;
  localparam logic [4:0] K_L = 5'b00100;
  localparam logic [4:0] K_R = 5'b01000;
  localparam logic [4:0] K_S = 5'b10000;

  // Instance 0: TICK 4, start (20,15); 1: start (37,15); 2: start (9,10); 3: TICK 64, start (20,15).
  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    snake_motion_ctrl #(
      .CELL_PX(16), .GRID_W(40), .GRID_H(30),
      .TICK_CYCLES(gi == 3 ? 64 : 4),
      .START_X(gi == 1 ? 37 : (gi == 2 ? 9 : 20)),
      .START_Y(gi == 2 ? 10 : 15),
      .SCORE_W(8)
    ) u_dut (
      .clk(clk), .resetn(resetn),
      .key_up(btn[0]), .key_down(btn[1]), .key_left(btn[2]), .key_right(btn[3]),
      .start(btn[4]), .painter_busy(busy),
      .x_min_px(xmin[gi]), .x_max_px(xmax[gi]), .y_min_px(ymin[gi]), .y_max_px(ymax[gi]),
      .fruit_cx(fcx[gi]), .fruit_cy(fcy[gi]),
      .redraw(rd[gi]), .game_over(go[gi]), .score(sc[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One cycle; outputs sampled 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (rd[i]) rd_cnt[i]++;
  endtask

  task automatic pulse(input logic [4:0] m);
    btn = m;
    repeat (3) step();
    btn = '0;
    repeat (3) step();
  endtask

  task automatic wait_rd(input int idx, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (rd[idx]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    btn    = '0;
    busy   = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
    step();
  endtask

  typedef struct {
    logic [4:0] k1;
    logic [4:0] k2;
    int         hx;
    int         hy;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int n, rc, fx, fy;

    vecs[0]  = '{5'b0,      5'b0, 21, 15};
    vecs[1]  = '{K_L,       5'b0, 22, 15};  // opposite of RIGHT: ignored
    vecs[2]  = '{K_U,       K_L,  22, 14};  // UP kept, later LEFT opposite: ignored
    vecs[3]  = '{K_D,       5'b0, 22, 13};  // opposite of UP
    vecs[4]  = '{K_L,       5'b0, 21, 13};
    vecs[5]  = '{K_U,       K_R,  21, 12};
    vecs[6]  = '{K_R,       5'b0, 22, 12};
    vecs[7]  = '{K_D,       5'b0, 22, 13};
    vecs[8]  = '{K_L | K_R, 5'b0, 21, 13};  // same cycle: left beats right
    vecs[9]  = '{K_U | K_D, 5'b0, 21, 12};  // same cycle: up beats down
    vecs[10] = '{K_L,       K_U,  21, 11};  // later edge overwrites pending
    vecs[11] = '{5'b0,      5'b0, 21, 10};

    btn = '0;
    busy = 1'b0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    chk("reset x_min", int'(xmin[0]), 320);
    chk("reset x_max", int'(xmax[0]), 335);
    chk("reset y_min", int'(ymin[0]), 240);
    chk("reset y_max", int'(ymax[0]), 255);
    chk("reset fruit_cx", int'(fcx[0]), 168);
    chk("reset fruit_cy", int'(fcy[0]), 168);
    chk("reset score", int'(sc[0]), 0);
    chk("reset game_over", int'(go[0]), 0);
    chk("reset redraw", int'(rd[0]), 0);

    // First move, tick period, painter busy hold
    apply_reset();
    pulse(K_S);
    wait_rd(0, 50, n);
    chk("A first redraw seen", (n > 0) ? 1 : 0, 1);
    chk("A x_min", int'(xmin[0]), 336);
    chk("A x_max", int'(xmax[0]), 351);
    chk("A y_min", int'(ymin[0]), 240);
    chk("A score", int'(sc[0]), 0);
    $display("A move1 head x_min=%0d y_min=%0d", xmin[0], ymin[0]);
    wait_rd(0, 50, n);
    chk("A redraw period", n, 5);
    chk("A move2 x_min", int'(xmin[0]), 352);
    step();
    busy = 1'b1;
    rc = rd_cnt[0];
    repeat (100) step();
    chk("D redraws while busy", rd_cnt[0] - rc, 0);
    chk("D single move while busy", int'(xmin[0]), 368);
    busy = 1'b0;
    #1;
    chk("D redraw on busy drop", int'(rd[0]), 1);
    rc = rd_cnt[0];
    wait_rd(0, 50, n);
    chk("D period after busy", n, 5);
    chk("D redraw count", rd_cnt[0] - rc, 1);
    chk("D move x_min", int'(xmin[0]), 384);
    $display("D busy hold done, head x_min=%0d", xmin[0]);

    // Right border
    apply_reset();
    pulse(K_S);
    wait_rd(1, 50, n);
    chk("B first redraw seen", (n > 0) ? 1 : 0, 1);
    chk("B x_min col 38", int'(xmin[1]), 608);
`ifdef SNAKE_WRAP_EN
    wait_rd(1, 50, n);
    chk("B wrap redraw seen", (n > 0) ? 1 : 0, 1);
    chk("B wrap x_min", int'(xmin[1]), 16);
    chk("B wrap game_over", int'(go[1]), 0);
    $display("B wrap head x_min=%0d", xmin[1]);
`else
    rc = rd_cnt[1];
    for (int i = 0; i < 30; i++) begin
      if (go[1]) break;
      step();
    end
    chk("B game_over", int'(go[1]), 1);
    chk("B head held", int'(xmin[1]), 608);
    repeat (20) step();
    chk("B no redraw after over", rd_cnt[1] - rc, 0);
    chk("B game_over held", int'(go[1]), 1);
    pulse(K_S);
    chk("B restart game_over", int'(go[1]), 0);
    chk("B restart x_min", int'(xmin[1]), 592);
    chk("B restart score", int'(sc[1]), 0);
    pulse(K_S);
    wait_rd(1, 50, n);
    chk("B replay redraw seen", (n > 0) ? 1 : 0, 1);
    chk("B replay x_min", int'(xmin[1]), 608);
    $display("B game over and restart, head x_min=%0d", xmin[1]);
`endif

    // Fruit capture, then asynchronous reset mid-run
    apply_reset();
    pulse(K_S);
    wait_rd(2, 500, n);
    chk("C redraw seen", (n > 0) ? 1 : 0, 1);
    chk("C score", int'(sc[2]), 1);
    chk("C x_min", int'(xmin[2]), 160);
    chk("C y_min", int'(ymin[2]), 160);
    fx = (int'(fcx[2]) - 8) / 16;
    fy = (int'(fcy[2]) - 8) / 16;
    chk("C fruit_cx grid aligned", (int'(fcx[2]) - 8) % 16, 0);
    chk("C fruit_cy grid aligned", (int'(fcy[2]) - 8) % 16, 0);
    chk("C fruit col range", (fx >= 1 && fx <= 38) ? 1 : 0, 1);
    chk("C fruit row range", (fy >= 1 && fy <= 28) ? 1 : 0, 1);
    chk("C fruit moved off head", (fx == 10 && fy == 10) ? 1 : 0, 0);
    $display("C fruit eaten, new fruit (%0d,%0d) score=%0d", fx, fy, sc[2]);
    step();
    step();
    resetn = 1'b0;
    #1;
    chk("R x_min", int'(xmin[2]), 144);
    chk("R y_min", int'(ymin[2]), 160);
    chk("R fruit_cx", int'(fcx[2]), 168);
    chk("R fruit_cy", int'(fcy[2]), 168);
    chk("R score", int'(sc[2]), 0);
    chk("R game_over", int'(go[2]), 0);
    chk("R redraw", int'(rd[2]), 0);
    chk("R inst0 x_min", int'(xmin[0]), 320);
    chk("R inst0 y_max", int'(ymax[0]), 255);

    // Direction handling, table driven
    apply_reset();
    pulse(K_S);
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].k1 != 5'b0) pulse(vecs[v].k1);
      if (vecs[v].k2 != 5'b0) pulse(vecs[v].k2);
      wait_rd(3, 200, n);
      chk($sformatf("K%0d redraw seen", v), (n > 0) ? 1 : 0, 1);
      chk($sformatf("K%0d x_min", v), int'(xmin[3]), vecs[v].hx * 16);
      chk($sformatf("K%0d y_min", v), int'(ymin[3]), vecs[v].hy * 16);
      $display("K%0d keys %b/%b head (%0d,%0d)", v, vecs[v].k1, vecs[v].k2,
               xmin[3] / 16, ymin[3] / 16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
